// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD drive arbiter.
//   arb_state_e  : channel FSM states (IDLE, ISSUE, WAIT_ACK, XFER)
//   arb_op_e     : latched operation of the current owner
//   client_mask  : client index -> one-hot client vector
package sd_arb_pkg;

  localparam int NCLIENT = 2;
  localparam int LBA_W   = 32;
  localparam int BUF_AW  = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    XFER     = 2'd3
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  function automatic logic [NCLIENT-1:0] client_mask(input logic idx);
    client_mask = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
//   req   : request per client
//   last  : client served most recently (loses a tie)
//   gnt   : one-hot grant, all zero when nothing is requested
//   valid : some client is granted
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/sd_drive_arbiter.sv
// Shares the single SD emulation channel of the data_io SPI bridge between
// two virtual-drive clients. One client's request is latched and presented
// as sd_lba/sd_rd/sd_wr; the sd_ack window is tracked and buffer strobes and
// data are steered to the owning client only.
//
// Handshake: a client holds c_rd/c_wr (level) until it sees its c_done or
// c_err pulse; both pulses are single-cycle and occur in the owner's last
// busy cycle, so a client dropping its request on that edge is never
// re-granted.
//
// Ports
//   clk_sd, reset_n        : clock, async active-low reset
//   c_rd, c_wr, c_lba      : client requests and {lba1,lba0}
//   c_busy, c_done, c_err  : per-client ownership / completion / abort
//   c_dout, c_dout_strobe  : read data and strobe to owner
//   c_din, c_din_strobe    : {din1,din0} write data and fetch strobe to owner
//   c_buff_addr            : bridge buffer address passthrough
//   sd_*                   : bridge side (data_io)
//   dbg_state              : current FSM state
module sd_drive_arbiter
  import sd_arb_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic                clk_sd,
  input  logic                reset_n,
  input  logic [NCLIENT-1:0]  c_rd,
  input  logic [NCLIENT-1:0]  c_wr,
  input  logic [2*LBA_W-1:0]  c_lba,
  output logic [NCLIENT-1:0]  c_busy,
  output logic [NCLIENT-1:0]  c_done,
  output logic [NCLIENT-1:0]  c_err,
  output logic [7:0]          c_dout,
  output logic [NCLIENT-1:0]  c_dout_strobe,
  input  logic [15:0]         c_din,
  output logic [NCLIENT-1:0]  c_din_strobe,
  output logic [BUF_AW-1:0]   c_buff_addr,
  output logic [LBA_W-1:0]    sd_lba,
  output logic [NCLIENT-1:0]  sd_rd,
  output logic [NCLIENT-1:0]  sd_wr,
  input  logic                sd_ack,
  input  logic [7:0]          sd_dout,
  input  logic                sd_dout_strobe,
  output logic [7:0]          sd_din,
  input  logic                sd_din_strobe,
  input  logic [BUF_AW-1:0]   sd_buff_addr,
  output logic [1:0]          dbg_state
);

  arb_state_e               state_q, state_d;
  logic                     owner_q, owner_d;
  arb_op_e                  op_q, op_d;
  logic [LBA_W-1:0]         lba_q, lba_d;
  logic [NCLIENT-1:0]       sd_rd_q, sd_rd_d;
  logic [NCLIENT-1:0]       sd_wr_q, sd_wr_d;
  logic [TIMEOUT_W-1:0]     cnt_q, cnt_d;
  logic                     ack_q;
  logic                     last_q, last_d;

  logic [NCLIENT-1:0]       pending;
  logic [NCLIENT-1:0]       gnt;
  logic                     gnt_valid;
  logic                     ack_rise, ack_fall;
  logic                     timeout;
  logic [NCLIENT-1:0]       owner_mask;

  assign pending    = c_rd | c_wr;
  assign ack_rise   = sd_ack & ~ack_q;
  assign ack_fall   = ~sd_ack & ack_q;
  assign owner_mask = client_mask(owner_q);

  // The counter runs 0,1,.. during WAIT_ACK; hitting 2**W-2 marks the
  // (2**W-1)-th wait cycle, which is the last one before aborting.
  assign timeout = (cnt_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  rr_arb2 u_rr (
    .req   (pending),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  // State register
  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (gnt_valid) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      // Only a rising edge counts: an ack left high from a previous
      // transfer must not start this one.
      WAIT_ACK: begin
        if (ack_rise)     state_d = XFER;
        else if (timeout) state_d = IDLE;
      end
      XFER:     if (ack_fall) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    owner_d = owner_q;
    op_d    = op_q;
    lba_d   = lba_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    cnt_d   = '0;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt[1];
          // Read wins over write from the same client; the write stays
          // pending and is granted as a separate request later.
          op_d    = c_rd[gnt[1]] ? OP_RD : OP_WR;
          lba_d   = gnt[0] ? c_lba[LBA_W-1:0] : c_lba[2*LBA_W-1:LBA_W];
        end
      end
      ISSUE: begin
        if (op_q == OP_RD) sd_rd_d = owner_mask;
        else               sd_wr_d = owner_mask;
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_rise || timeout) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
        end
        if (!ack_rise && timeout) last_d = owner_q;
      end
      XFER: begin
        if (ack_fall) last_d = owner_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sd or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      op_q    <= OP_RD;
      lba_q   <= '0;
      sd_rd_q <= '0;
      sd_wr_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      last_q  <= 1'b1;   // client 0 wins the first tie
    end else begin
      owner_q <= owner_d;
      op_q    <= op_d;
      lba_q   <= lba_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      cnt_q   <= cnt_d;
      ack_q   <= sd_ack;
      last_q  <= last_d;
    end
  end

  // Output logic
  always_comb begin
    c_busy        = '0;
    c_done        = '0;
    c_err         = '0;
    c_dout        = '0;
    c_dout_strobe = '0;
    c_din_strobe  = '0;
    if (state_q != IDLE) c_busy = owner_mask;
    if (state_q == XFER) begin
      c_dout = sd_dout;
      if (sd_dout_strobe) c_dout_strobe = owner_mask;
      if (sd_din_strobe)  c_din_strobe  = owner_mask;
      if (ack_fall)       c_done        = owner_mask;
    end
    if (state_q == WAIT_ACK && timeout && !ack_rise) c_err = owner_mask;
  end

  assign c_buff_addr = sd_buff_addr;
  assign sd_din      = owner_q ? c_din[15:8] : c_din[7:0];
  assign sd_lba      = lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
module tb_sd_drive_arbiter;

  logic        clk_sd;
  logic        reset_n;
  logic [1:0]  c_rd, c_wr;
  logic [63:0] c_lba;
  logic [1:0]  c_busy, c_done, c_err;
  logic [7:0]  c_dout;
  logic [1:0]  c_dout_strobe;
  logic [15:0] c_din;
  logic [1:0]  c_din_strobe;
  logic [8:0]  c_buff_addr;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_dout;
  logic        sd_dout_strobe;
  logic [7:0]  sd_din;
  logic        sd_din_strobe;
  logic [8:0]  sd_buff_addr;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int m_last = 1;            // reference model: client served most recently
  logic [7:0] exp_q[$];

  sd_drive_arbiter #(.TIMEOUT_W(4)) dut (
    .clk_sd         (clk_sd),
    .reset_n        (reset_n),
    .c_rd           (c_rd),
    .c_wr           (c_wr),
    .c_lba          (c_lba),
    .c_busy         (c_busy),
    .c_done         (c_done),
    .c_err          (c_err),
    .c_dout         (c_dout),
    .c_dout_strobe  (c_dout_strobe),
    .c_din          (c_din),
    .c_din_strobe   (c_din_strobe),
    .c_buff_addr    (c_buff_addr),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_ack         (sd_ack),
    .sd_dout        (sd_dout),
    .sd_dout_strobe (sd_dout_strobe),
    .sd_din         (sd_din),
    .sd_din_strobe  (sd_din_strobe),
    .sd_buff_addr   (sd_buff_addr),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  initial begin
    clk_sd = 1'b0;
    forever #5 clk_sd = ~clk_sd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Drivers
  task automatic tick();
    @(posedge clk_sd);
    #2;
  endtask

  // Reference arbitration rule: a lone requester wins; on a tie the client
  // that was not served last wins.
  function automatic int model_pick(input logic [1:0] pend);
    if (pend == 2'b11) return 1 - m_last;
    if (pend[1]) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] mask_of(input int c);
    return (c == 1) ? 2'b10 : 2'b01;
  endfunction

  // Plays the data_io side of one transfer for the expected client, checking
  // issue, stray strobes, steering and data; ends in the done cycle.
  task automatic bridge_xfer(input int c, input bit is_wr, input logic [31:0] lba, input int nbytes);
    int waited;
    int hold;
    int nstb;
    logic [1:0] m;
    logic [7:0] e;
    m = mask_of(c);
    exp_q.delete();
    nstb = 0;
    waited = 0;
    while ((sd_rd | sd_wr) == 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if ((sd_rd | sd_wr) == 2'b00) begin
      errors++;
      $display("FAIL issue_wait: got no sd_rd/sd_wr after %0d cycles, required client %0d", waited, c);
      return;
    end
    checks++;
    if (sd_rd !== (is_wr ? 2'b00 : m) || sd_wr !== (is_wr ? m : 2'b00)) begin
      errors++;
      $display("FAIL issue_dir: got rd=%b wr=%b, required client %0d wr=%0d", sd_rd, sd_wr, c, is_wr);
    end
    checks++;
    if (sd_lba !== lba) begin
      errors++;
      $display("FAIL issue_lba: got %h required %h", sd_lba, lba);
    end
    checks++;
    if (c_busy !== m) begin
      errors++;
      $display("FAIL busy_wait: got %b required %b", c_busy, m);
    end
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      sd_dout_strobe = 1'b1;
      sd_din_strobe  = 1'b1;
      #1;
      checks++;
      if (c_dout_strobe !== 2'b00 || c_din_strobe !== 2'b00) begin
        errors++;
        $display("FAIL stray_strobe: got dout=%b din=%b required 00", c_dout_strobe, c_din_strobe);
      end
      sd_dout_strobe = 1'b0;
      sd_din_strobe  = 1'b0;
      tick();
      checks++;
      if ((sd_rd | sd_wr) !== m) begin
        errors++;
        $display("FAIL issue_hold: got %b required %b", sd_rd | sd_wr, m);
      end
    end
    sd_ack = 1'b1;
    tick();
    checks++;
    if (sd_rd !== 2'b00 || sd_wr !== 2'b00 || c_busy !== m) begin
      errors++;
      $display("FAIL ack_deassert: got rd=%b wr=%b busy=%b required 00 00 %b", sd_rd, sd_wr, c_busy, m);
    end
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      sd_buff_addr = 9'(i);
      c_din = 16'($urandom);
      if (!is_wr) begin
        sd_dout = 8'($urandom);
        sd_dout_strobe = 1'b1;
        exp_q.push_back(sd_dout);
      end else begin
        sd_din_strobe = 1'b1;
        exp_q.push_back((c == 1) ? c_din[15:8] : c_din[7:0]);
      end
      #1;
      if (((is_wr ? c_din_strobe : c_dout_strobe) & m) != 2'b00 && exp_q.size() > 0) begin
        nstb++;
        e = exp_q.pop_front();
        checks++;
        if ((is_wr ? sd_din : c_dout) !== e) begin
          errors++;
          $display("FAIL xfer_data: byte %0d got %h required %h", i, is_wr ? sd_din : c_dout, e);
        end
      end
      checks++;
      if (((c_dout_strobe | c_din_strobe) & ~m) !== 2'b00) begin
        errors++;
        $display("FAIL nonowner_strobe: got dout=%b din=%b owner %0d", c_dout_strobe, c_din_strobe, c);
      end
      checks++;
      if (c_buff_addr !== 9'(i)) begin
        errors++;
        $display("FAIL buff_addr: got %0d required %0d", c_buff_addr, i);
      end
      tick();
      sd_dout_strobe = 1'b0;
      sd_din_strobe  = 1'b0;
    end
    checks++;
    if (nstb != nbytes || exp_q.size() != 0) begin
      errors++;
      $display("FAIL strobe_count: got %0d required %0d", nstb, nbytes);
    end
    tick();
    sd_ack = 1'b0;
    #1;
    checks++;
    if (c_done !== m || c_err !== 2'b00) begin
      errors++;
      $display("FAIL done_pulse: got done=%b err=%b required %b 00", c_done, c_err, m);
    end
    m_last = c;
  endtask

  // One cycle after the owner's last cycle: channel idle, no repeated pulse.
  task automatic idle_check();
    tick();
    checks++;
    if (c_busy !== 2'b00 || c_done !== 2'b00 || c_err !== 2'b00 || sd_rd !== 2'b00 || sd_wr !== 2'b00) begin
      errors++;
      $display("FAIL idle_after: got busy=%b done=%b err=%b rd=%b wr=%b required all 0",
               c_busy, c_done, c_err, sd_rd, sd_wr);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (c_busy !== 0 || c_done !== 0 || c_err !== 0 || c_dout_strobe !== 0 || c_din_strobe !== 0 ||
        c_dout !== 0 || sd_rd !== 0 || sd_wr !== 0 || sd_lba !== 0 || dbg_state !== 0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b err=%b dstb=%b istb=%b dout=%h rd=%b wr=%b lba=%h st=%0d required all 0",
               name, c_busy, c_done, c_err, c_dout_strobe, c_din_strobe, c_dout, sd_rd, sd_wr, sd_lba, dbg_state);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    c_rd = 0; c_wr = 0; c_lba = 0; c_din = 0;
    sd_ack = 0; sd_dout = 0; sd_dout_strobe = 0; sd_din_strobe = 0; sd_buff_addr = 0;
    #1;
    check_all_zero("reset_async");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check_all_zero("reset_release");
    m_last = 1;
  endtask

  task automatic test_read_basic();
    c_lba = {32'h0, 32'h0000_1234};
    c_rd  = 2'b01;
    tick();
    checks++;
    if (c_busy !== 2'b01 || sd_rd !== 2'b00) begin
      errors++;
      $display("FAIL issue_cycle: got busy=%b rd=%b required 01 00", c_busy, sd_rd);
    end
    tick();
    checks++;
    if (sd_rd !== 2'b01 || sd_lba !== 32'h1234) begin
      errors++;
      $display("FAIL read_latency: got rd=%b lba=%h required 01 00001234", sd_rd, sd_lba);
    end
    bridge_xfer(0, 1'b0, 32'h1234, 512);
    c_rd = 2'b00;
    idle_check();
  endtask

  task automatic test_fairness();
    int p;
    int prev;
    c_lba = {32'($urandom), 32'($urandom)};
    c_rd  = 2'b11;
    prev  = m_last;
    for (int r = 0; r < 4; r++) begin
      p = model_pick(c_rd | c_wr);
      checks++;
      if (p == prev) begin
        errors++;
        $display("FAIL fair_model: got client %0d twice, required alternation", p);
      end
      prev = p;
      bridge_xfer(p, 1'b0, (p == 1) ? c_lba[63:32] : c_lba[31:0], 4);
      if (r == 3) c_rd = 2'b00;
      idle_check();
    end
  endtask

  task automatic test_write();
    c_lba[63:32] = 32'($urandom);
    c_wr = 2'b10;
    bridge_xfer(1, 1'b1, c_lba[63:32], 16);
    c_wr = 2'b00;
    idle_check();
  endtask

  task automatic test_stale_ack();
    c_lba[63:32] = 32'($urandom);
    c_rd = 2'b10;
    tick();
    sd_ack = 1'b1;            // ack already high while issuing
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (sd_rd !== 2'b10 || dbg_state !== 2'd2) begin
        errors++;
        $display("FAIL stale_ack: got rd=%b state=%0d required 10 2", sd_rd, dbg_state);
      end
    end
    sd_ack = 1'b0;
    tick();
    bridge_xfer(1, 1'b0, c_lba[63:32], 3);
    c_rd = 2'b00;
    idle_check();
  endtask

  task automatic test_timeout();
    int n;
    int w;
    c_rd = 2'b01;
    w = 0;
    while (sd_rd === 2'b00 && w < 10) begin
      tick();
      w++;
    end
    n = 1;
    while (c_err === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15 || c_err !== 2'b01 || sd_rd !== 2'b01) begin
      errors++;
      $display("FAIL timeout_err: got err=%b after %0d wait cycles rd=%b, required 01 after 15 rd=01", c_err, n, sd_rd);
    end
    m_last = 0;
    c_rd = 2'b00;
    idle_check();
  endtask

  task automatic test_random();
    int p;
    bit wr;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 2; k++) begin
        if (c_rd[k] == 1'b0 && c_wr[k] == 1'b0 && $urandom_range(0, 1) == 1) begin
          c_lba[k*32 +: 32] = 32'($urandom);
          c_rd[k] = 1'($urandom);
          c_wr[k] = 1'($urandom);
        end
      end
      if ((c_rd | c_wr) == 2'b00) c_wr[$urandom_range(0, 1)] = 1'b1;
      p  = model_pick(c_rd | c_wr);
      wr = !c_rd[p];
      bridge_xfer(p, wr, c_lba[p*32 +: 32], $urandom_range(1, 6));
      if (wr) c_wr[p] = 1'b0;
      else    c_rd[p] = 1'b0;
      if (r == 11) begin
        c_rd = 2'b00;
        c_wr = 2'b00;
      end
      idle_check();
    end
  endtask

  task automatic test_reset_mid();
    int w;
    c_lba[31:0] = 32'($urandom);
    c_rd = 2'b01;
    w = 0;
    while (sd_rd === 2'b00 && w < 10) begin
      tick();
      w++;
    end
    sd_ack = 1'b1;
    tick();
    sd_dout = 8'hA5;
    sd_dout_strobe = 1'b1;
    #1;
    checks++;
    if (c_dout_strobe !== 2'b01) begin
      errors++;
      $display("FAIL mid_xfer: got %b required 01", c_dout_strobe);
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    sd_ack = 1'b0;
    sd_dout_strobe = 1'b0;
    tick();
    reset_n = 1'b1;
    m_last = 1;
    bridge_xfer(0, 1'b0, c_lba[31:0], 4);
    c_rd = 2'b00;
    idle_check();
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_read_basic();
    test_fairness();
    test_write();
    test_stale_ack();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
